// File: rtl/lstm_cell_state_update.sv
// Element-wise LSTM cell-state update c_new = f*c_prev + i*g, with an internal
// per-element cell-state memory that is zeroed after reset or on a clear request.
module lstm_cell_state_update #(
    parameter int BITWIDTH = 18,
    parameter int FRAC     = 12,
    parameter int NELEM    = 32,
    parameter int ADDRW    = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear_state,
    input  logic                       valid_in,
    output logic                       in_ready,
    input  logic signed [BITWIDTH-1:0] gate_i,
    input  logic signed [BITWIDTH-1:0] gate_f,
    input  logic signed [BITWIDTH-1:0] gate_g,
    output logic                       valid_out,
    output logic signed [BITWIDTH-1:0] c_out,
    output logic [ADDRW-1:0]           idx_out,
    output logic                       last_out
);
    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int PW = 2 * BITWIDTH;
    localparam int SW = BITWIDTH + 2;
    localparam logic [ADDRW-1:0]     LAST_IDX = ADDRW'(NELEM - 1);
    localparam logic signed [SW-1:0] SAT_MAX  = SW'((2 ** (BITWIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN  = SW'(-(2 ** (BITWIDTH - 1)));

    // Full-width product, floored back to Q-format; gates in [-1,1] keep it within BITWIDTH+1 bits.
    function automatic logic signed [BITWIDTH:0] mul_q(input logic signed [BITWIDTH-1:0] a,
                                                       input logic signed [BITWIDTH-1:0] b);
        logic signed [PW-1:0] prod;
        prod = PW'(a) * PW'(b);
        prod = prod >>> FRAC;
        return prod[BITWIDTH:0];
    endfunction

    function automatic logic signed [BITWIDTH-1:0] saturate(input logic signed [SW-1:0] x);
        if (x > SAT_MAX) return {1'b0, {(BITWIDTH-1){1'b1}}};
        if (x < SAT_MIN) return {1'b1, {(BITWIDTH-1){1'b0}}};
        return x[BITWIDTH-1:0];
    endfunction

    logic [1:0]       state;
    logic [ADDRW-1:0] idx;
    logic [ADDRW-1:0] clr_addr;
    logic             accept;

    logic signed [BITWIDTH-1:0] mem [NELEM];

    logic signed [BITWIDTH-1:0] gi_p0, gf_p0, gg_p0;
    logic [ADDRW-1:0]           addr_p0;
    logic                       vld_p0;
    logic signed [BITWIDTH-1:0] gi_p1, gf_p1, gg_p1, cprev_p1;
    logic [ADDRW-1:0]           addr_p1;
    logic                       vld_p1;
    logic signed [BITWIDTH:0]   pf_p2, pi_p2;
    logic [ADDRW-1:0]           addr_p2;
    logic                       vld_p2;

    logic signed [SW-1:0]       sum_p2;
    logic signed [BITWIDTH-1:0] c_new;
    logic                       mem_we;
    logic [ADDRW-1:0]           mem_waddr;
    logic signed [BITWIDTH-1:0] mem_wdata;

    assign in_ready = (state == ST_RUN);
    assign accept   = valid_in && in_ready && !clear_state;
    assign sum_p2   = SW'(pf_p2) + SW'(pi_p2);
    assign c_new    = saturate(sum_p2);

    // The pipeline is always empty while clearing, so the two writers never collide.
    always_comb begin
        mem_we    = (state == ST_CLEAR) || vld_p2;
        mem_waddr = addr_p2;
        mem_wdata = c_new;
        if (state == ST_CLEAR) begin
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            idx       <= '0;
            clr_addr  <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            valid_out <= 1'b0;
            c_out     <= '0;
            idx_out   <= '0;
            last_out  <= 1'b0;
        end else begin
            vld_p0    <= accept;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            valid_out <= vld_p2;
            if (vld_p2) begin
                c_out    <= c_new;
                idx_out  <= addr_p2;
                last_out <= (addr_p2 == LAST_IDX);
            end
            case (state)
                ST_CLEAR: begin
                    idx <= '0;
                    if (clr_addr == LAST_IDX) begin
                        clr_addr <= '0;
                        state    <= ST_RUN;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_state) begin
                        state <= ST_DRAIN;
                        idx   <= '0;
                    end else if (accept) begin
                        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    idx      <= '0;
                    clr_addr <= '0;
                    if (!(vld_p0 || vld_p1 || vld_p2)) state <= ST_CLEAR;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // stage 0: gates and element address
        gi_p0    <= gate_i;
        gf_p0    <= gate_f;
        gg_p0    <= gate_g;
        addr_p0  <= idx;
        // stage 1: previous cell state read
        gi_p1    <= gi_p0;
        gf_p1    <= gf_p0;
        gg_p1    <= gg_p0;
        cprev_p1 <= mem[addr_p0];
        addr_p1  <= addr_p0;
        // stage 2: Q-format products
        pf_p2    <= mul_q(gf_p1, cprev_p1);
        pi_p2    <= mul_q(gi_p1, gg_p1);
        addr_p2  <= addr_p1;
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
endmodule

// File: doc/lstm_cell_state_update.md
Name: lstm_cell_state_update

Overview:
- Element-wise LSTM cell-state stage directly upstream of the tanh unit.
- Accepts one element of the activated gate vectors (i, f, g) per cycle and reads the previous cell state c_prev from an internal NELEM-entry state memory.
- Computes c_new = f*c_prev + i*g in signed fixed point, writes c_new back to memory and presents it on c_out as the tanh operand.
- c_out also carries c_new to the hidden-state multiplier path.

Parameters:
BITWIDTH, 18, data word width, signed two's complement
FRAC, 12, fractional bits (1.0 = 4096)
NELEM, 32, cell vector length; must be >= 4
ADDRW, 5, element index width; 2^ADDRW >= NELEM

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
clear_state  in  1  single-cycle request to zero all stored cell state
valid_in  in  1  gate element valid
in_ready  out  1  stage can accept an element this cycle
gate_i  in  BITWIDTH  input gate, sigmoid output, range [0,1]
gate_f  in  BITWIDTH  forget gate, sigmoid output, range [0,1]
gate_g  in  BITWIDTH  candidate, tanh output, range [-1,1]
valid_out  out  1  c_out valid
c_out  out  BITWIDTH  new cell state, feeds tanh operand
idx_out  out  ADDRW  element index of c_out
last_out  out  1  c_out is element NELEM-1

Behaviour:
- Transfer: an element is accepted when valid_in && in_ready at a rising edge. valid_in while in_ready=0 is ignored. No output backpressure: the tanh stage always accepts.
- in_ready = (state==RUN).
- Element counter idx:
  - 0 after reset and after CLEAR.
  - Increments on each accept; wraps NELEM-1 -> 0.
  - Accepted element k uses memory address idx.
- Pipeline, 3 stages, latency 3:
  - S1: register gates; issue memory read at idx.
  - S2: p_f = f*c_prev and p_i = i*g as 2*BITWIDTH signed products, each arithmetic-shifted right by FRAC (truncation toward -inf).
  - S3: sum in BITWIDTH+2 bits; saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]; write back to memory[idx]; drive c_out, idx_out, last_out, valid_out.
  - An element accepted at edge n appears with valid_out=1 after edge n+3.
  - Throughput is one element per cycle.
- Hazard: consecutive accepts always target different addresses (NELEM >= 4), so no forwarding is needed. Write-back completes before the same address is read again.
- State machine:
  - CLEAR: in_ready=0. Writes 0 to addresses 0..NELEM-1, one per cycle, over NELEM cycles, then goes to RUN with idx=0.
  - RUN: normal operation. clear_state=1 goes to DRAIN.
  - DRAIN: in_ready=0. Aborts the current vector (idx forced to 0). Waits until all in-flight elements have emitted valid_out (at most 3 cycles), then goes to CLEAR.
  - clear_state outside RUN is ignored.
  - valid_in and clear_state in the same RUN cycle: clear wins and the element is not accepted.
- Reset (reset=0 at an edge, including mid-vector):
  - valid_out=0, c_out=0, idx_out=0, last_out=0.
  - All pipeline valids flushed; idx=0.
  - State = CLEAR, so in_ready=0 and memory is zeroed over the NELEM cycles after reset is released.
- Outputs hold their last value when valid_out=0. Consumers qualify on valid_out.

Test Plan:
- Reset held 2 cycles, then released -> in_ready=0 for exactly 32 cycles, then 1; valid_out=0 throughout.
- Vector 1: all 32 elements with i=4096, f=2048, g=2048, valid_in every cycle -> c_out=2048 for every element; each valid_out is 3 cycles after its accept; idx_out runs 0..31; last_out=1 only with idx 31.
- Vector 2 with identical gates -> c_out=3072 for all elements (0.5*2048 + 2048). Repeat with gaps in valid_in -> same values; valid_out pattern is the input pattern delayed by 3.
- Positive saturation: f=i=g=4096 for 32 vectors -> element 0 reads 4096*k after vector k; vector 32 gives 131071 (saturated, not 131072). Negative case, g=-4096 for 33 vectors -> -131072, no wrap.
- clear_state asserted after element 10 of a vector -> in_ready=0 immediately; elements 8..10 still emerge on valid_out; after DRAIN plus 32 CLEAR cycles in_ready=1. The next vector with i=4096, f=4096, g=1024 gives c_out=1024 for all elements, including 0..10.
- Reset asserted mid-vector with elements in flight -> no valid_out after the reset edge; behaviour identical to the power-on case (32-cycle CLEAR); the next vector computes from c_prev=0.
